// File: rtl/tensor_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tensor_cmd_scheduler
//
// Shares the single tensor_interface configuration port among NUM_REQ
// requesters. A round-robin arbiter picks one descriptor at a time and holds it
// on cfg_* until tensor_interface accepts it. The number of descriptors that
// have been accepted but not yet completed is capped at MAX_OUT. Completion
// pulses arrive in issue order, so a small FIFO of requester ids returns each
// pulse to the requester that issued the descriptor.
//
// Ports
//   clock          : clock, all logic on posedge
//   reset_n        : synchronous active-low reset
//   req_tdata      : descriptor of requester i at [i*DESC_W +: DESC_W]
//   req_tvalid     : per-requester descriptor valid
//   req_tready     : per-requester accept (one-hot or zero, combinational)
//   cfg_tdata      : descriptor to tensor_interface (held until accepted)
//   cfg_tvalid     : descriptor valid to tensor_interface
//   cfg_tready     : tensor_interface accept
//   cmp_valid      : one-cycle pulse per completed descriptor, in issue order
//   done_valid     : one-cycle completion pulse to requesters
//   done_id        : requester id belonging to done_valid
//   outstanding    : number of accepted, not yet completed descriptors
//   busy           : FSM not idle or outstanding != 0
//   err_underflow  : sticky; completion seen with nothing outstanding
// -----------------------------------------------------------------------------
module tensor_cmd_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DESC_W  = 107,
  parameter int MAX_OUT = 4,
  parameter int ID_W    = 2
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NUM_REQ*DESC_W-1:0]   req_tdata,
  input  logic [NUM_REQ-1:0]          req_tvalid,
  output logic [NUM_REQ-1:0]          req_tready,
  output logic [DESC_W-1:0]           cfg_tdata,
  output logic                        cfg_tvalid,
  input  logic                        cfg_tready,
  input  logic                        cmp_valid,
  output logic                        done_valid,
  output logic [ID_W-1:0]             done_id,
  output logic [$clog2(MAX_OUT):0]    outstanding,
  output logic                        busy,
  output logic                        err_underflow
);

  localparam int AW    = $clog2(MAX_OUT);
  localparam int CNT_W = AW + 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   held_id;

  // Id FIFO: pointers carry one extra bit and wrap naturally.
  logic [ID_W-1:0]   id_fifo [MAX_OUT];
  logic [CNT_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  rd_ptr;

  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   cand;
  logic              grant;
  logic              push;
  logic              pop;
  logic [DESC_W-1:0] win_desc;

  // Winner search: first valid requester upward from rr_ptr + 1, wrapping at
  // NUM_REQ. The last candidate examined is rr_ptr itself.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!win_found && req_tvalid[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  // Grants only happen in IDLE, where a pending descriptor cannot exist, so the
  // cap check reduces to outstanding < MAX_OUT.
  assign grant    = (state == IDLE) && win_found && (outstanding < CNT_W'(MAX_OUT));
  assign push     = (state == ISSUE) && cfg_tready;
  assign pop      = cmp_valid && (outstanding != '0);
  assign win_desc = req_tdata[win_id*DESC_W +: DESC_W];

  always_comb begin
    req_tready = '0;
    if (grant) req_tready[win_id] = 1'b1;
  end

  assign busy = (state != IDLE) || (outstanding != '0);

  // ---- issue stage: arbitration, descriptor hold, cfg handshake ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      held_id    <= '0;
      cfg_tdata  <= '0;
      cfg_tvalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            cfg_tdata  <= win_desc;
            held_id    <= win_id;
            rr_ptr     <= win_id;
            cfg_tvalid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (cfg_tready) begin
            cfg_tvalid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Id storage carries no reset; emptiness is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push) id_fifo[wr_ptr[AW-1:0]] <= held_id;
  end

  // ---- completion stage: id FIFO pointers, count, done pulse ----
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding   <= '0;
      done_valid    <= 1'b0;
      done_id       <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        done_id <= id_fifo[rd_ptr[AW-1:0]];
      end
      done_valid  <= pop;
      outstanding <= outstanding + CNT_W'(push) - CNT_W'(pop);
      if (cmp_valid && (outstanding == '0)) err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tensor_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tensor_cmd_scheduler
//
// Directed bench for tensor_cmd_scheduler (NUM_REQ=4, DESC_W=107, MAX_OUT=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// and combinational req_tready is sampled one more unit after inputs change.
// -----------------------------------------------------------------------------
module tb_tensor_cmd_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DESC_W  = 107;
  localparam int MAX_OUT = 4;
  localparam int ID_W    = 2;

  logic                      clock;
  logic                      reset_n;
  logic [NUM_REQ*DESC_W-1:0] req_tdata;
  logic [NUM_REQ-1:0]        req_tvalid;
  logic [NUM_REQ-1:0]        req_tready;
  logic [DESC_W-1:0]         cfg_tdata;
  logic                      cfg_tvalid;
  logic                      cfg_tready;
  logic                      cmp_valid;
  logic                      done_valid;
  logic [ID_W-1:0]           done_id;
  logic [$clog2(MAX_OUT):0]  outstanding;
  logic                      busy;
  logic                      err_underflow;

  int n_chk  = 0;
  int n_fail = 0;

  tensor_cmd_scheduler #(
    .NUM_REQ(NUM_REQ), .DESC_W(DESC_W), .MAX_OUT(MAX_OUT), .ID_W(ID_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
    .cmp_valid(cmp_valid), .done_valid(done_valid), .done_id(done_id),
    .outstanding(outstanding), .busy(busy), .err_underflow(err_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DESC_W-1:0] desc_of(input int id);
    return {2'b10, 3'(id), 11'h123 + 11'(id), 40'hDEADBEEF00 + 40'(id),
            11'h7A5, 40'h00000000A5 + 40'(id * 16)};
  endfunction

  function automatic logic [127:0] oh(input int i);
    return 128'(1) << i;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Grant requester id from IDLE and complete the cfg handshake one cycle later.
  task automatic grant_and_issue(input int id);
    req_tvalid = 4'(1 << id);
    #1;
    check("gi_ready", 128'(req_tready), oh(id));
    tick();
    req_tvalid = '0;
    check("gi_cfg_valid", 128'(cfg_tvalid), 128'd1);
    check("gi_cfg_data", 128'(cfg_tdata), 128'(desc_of(id)));
    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
  endtask

  int rr_exp[6]  = '{0, 1, 2, 3, 0, 1};
  int cap_exp[4] = '{0, 1, 2, 3};

  initial begin
    reset_n    = 1'b0;
    req_tvalid = '0;
    cfg_tready = 1'b0;
    cmp_valid  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_tdata[i*DESC_W +: DESC_W] = desc_of(i);

    // ---- reset state ----
    tick();
    tick();
    check("rst_cfg_valid", 128'(cfg_tvalid), 128'd0);
    check("rst_cfg_data", 128'(cfg_tdata), 128'd0);
    check("rst_done_valid", 128'(done_valid), 128'd0);
    check("rst_done_id", 128'(done_id), 128'd0);
    check("rst_outstanding", 128'(outstanding), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_err", 128'(err_underflow), 128'd0);
    check("rst_ready", 128'(req_tready), 128'd0);
    reset_n = 1'b1;
    tick();

    // ---- single issue ----
    req_tvalid = 4'b0001;
    #1;
    check("single_ready", 128'(req_tready), 128'h1);
    tick();
    req_tvalid = '0;
    check("single_cfg_valid", 128'(cfg_tvalid), 128'd1);
    check("single_cfg_data", 128'(cfg_tdata), 128'(desc_of(0)));
    check("single_busy", 128'(busy), 128'd1);
    tick();
    check("single_hold", 128'(cfg_tvalid), 128'd1);
    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
    check("single_cfg_drop", 128'(cfg_tvalid), 128'd0);
    check("single_out1", 128'(outstanding), 128'd1);
    tick();
    tick();
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    check("single_done_valid", 128'(done_valid), 128'd1);
    check("single_done_id", 128'(done_id), 128'd0);
    check("single_out0", 128'(outstanding), 128'd0);
    tick();
    check("single_done_pulse", 128'(done_valid), 128'd0);
    check("single_idle", 128'(busy), 128'd0);

    // ---- round robin with overlapping completions ----
    do_reset();
    req_tvalid = 4'b1111;
    cfg_tready = 1'b1;
    #1;
    for (int g = 0; g < 6; g++) begin
      if (g >= 2) begin
        check("rr_done_valid", 128'(done_valid), 128'd1);
        check("rr_done_id", 128'(done_id), 128'(rr_exp[g-2]));
      end else begin
        check("rr_done_quiet", 128'(done_valid), 128'd0);
      end
      check("rr_grant", 128'(req_tready), oh(rr_exp[g]));
      tick();
      check("rr_cfg_data", 128'(cfg_tdata), 128'(desc_of(rr_exp[g])));
      check("rr_issue_ready", 128'(req_tready), 128'd0);
      if (g >= 1) cmp_valid = 1'b1;
      tick();
      cmp_valid = 1'b0;
      check("rr_outstanding", 128'(outstanding), 128'd1);
    end
    req_tvalid = '0;
    cfg_tready = 1'b0;
    check("rr_tail_done", 128'(done_id), 128'(rr_exp[4]));
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    check("rr_last_done", 128'(done_id), 128'(rr_exp[5]));
    check("rr_drained", 128'(outstanding), 128'd0);

    // ---- backpressure: 7 cycles held, handshake on the 8th ----
    req_tvalid = 4'b1100;
    #1;
    check("bp_grant", 128'(req_tready), oh(2));
    tick();
    req_tvalid = 4'b1000;
    #1;
    for (int i = 0; i < 7; i++) begin
      check("bp_valid", 128'(cfg_tvalid), 128'd1);
      check("bp_data", 128'(cfg_tdata), 128'(desc_of(2)));
      check("bp_ready", 128'(req_tready), 128'd0);
      tick();
    end
    cfg_tready = 1'b1;
    #1;
    check("bp_hs_ready", 128'(req_tready), 128'd0);
    tick();
    cfg_tready = 1'b0;
    check("bp_next_grant", 128'(req_tready), oh(3));
    tick();
    req_tvalid = '0;
    check("bp_next_data", 128'(cfg_tdata), 128'(desc_of(3)));
    cfg_tready = 1'b1;
    tick();
    cfg_tready = 1'b0;
    check("bp_out2", 128'(outstanding), 128'd2);
    cmp_valid = 1'b1;
    tick();
    check("bp_done_a", 128'(done_id), 128'd2);
    tick();
    cmp_valid = 1'b0;
    check("bp_done_b", 128'(done_id), 128'd3);
    check("bp_out0", 128'(outstanding), 128'd0);

    // ---- outstanding cap ----
    req_tvalid = 4'b1111;
    cfg_tready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("cap_grant", 128'(req_tready), oh(cap_exp[k]));
      tick();
      tick();
    end
    check("cap_full", 128'(outstanding), 128'd4);
    check("cap_blocked", 128'(req_tready), 128'd0);
    tick();
    tick();
    check("cap_no_issue", 128'(cfg_tvalid), 128'd0);
    check("cap_still_blocked", 128'(req_tready), 128'd0);
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    check("cap_done_id", 128'(done_id), 128'd0);
    check("cap_out3", 128'(outstanding), 128'd3);
    check("cap_regrant", 128'(req_tready), oh(0));
    tick();
    check("cap_regrant_data", 128'(cfg_tdata), 128'(desc_of(0)));
    tick();
    check("cap_refull", 128'(outstanding), 128'd4);
    check("cap_reblocked", 128'(req_tready), 128'd0);

    // ---- simultaneous push/pop, then underflow ----
    req_tvalid = '0;
    cmp_valid  = 1'b1;
    tick();
    check("pp_drain_a", 128'(done_id), 128'd1);
    tick();
    cmp_valid = 1'b0;
    check("pp_drain_b", 128'(done_id), 128'd2);
    check("pp_out2", 128'(outstanding), 128'd2);
    req_tvalid = 4'b0010;
    #1;
    check("pp_grant", 128'(req_tready), oh(1));
    tick();
    req_tvalid = '0;
    cmp_valid  = 1'b1;
    tick();
    cmp_valid  = 1'b0;
    cfg_tready = 1'b0;
    check("pp_out_same", 128'(outstanding), 128'd2);
    check("pp_done_valid", 128'(done_valid), 128'd1);
    check("pp_done_oldest", 128'(done_id), 128'd3);
    cmp_valid = 1'b1;
    tick();
    check("pp_done_c", 128'(done_id), 128'd0);
    tick();
    check("pp_done_d", 128'(done_id), 128'd1);
    check("pp_out0", 128'(outstanding), 128'd0);
    check("pp_no_err_yet", 128'(err_underflow), 128'd0);
    tick();
    cmp_valid = 1'b0;
    check("uf_no_done", 128'(done_valid), 128'd0);
    check("uf_err", 128'(err_underflow), 128'd1);
    check("uf_out0", 128'(outstanding), 128'd0);
    tick();
    check("uf_sticky", 128'(err_underflow), 128'd1);

    // ---- reset while a descriptor is held ----
    do_reset();
    check("mr_err_clear", 128'(err_underflow), 128'd0);
    grant_and_issue(0);
    grant_and_issue(1);
    grant_and_issue(2);
    req_tvalid = 4'b1000;
    #1;
    check("mr_grant", 128'(req_tready), oh(3));
    tick();
    req_tvalid = '0;
    check("mr_held", 128'(cfg_tvalid), 128'd1);
    check("mr_out3", 128'(outstanding), 128'd3);
    reset_n = 1'b0;
    tick();
    check("mr_cfg_valid", 128'(cfg_tvalid), 128'd0);
    check("mr_cfg_data", 128'(cfg_tdata), 128'd0);
    check("mr_out0", 128'(outstanding), 128'd0);
    check("mr_busy", 128'(busy), 128'd0);
    reset_n = 1'b1;
    tick();
    cmp_valid = 1'b1;
    tick();
    cmp_valid = 1'b0;
    check("mr_no_done", 128'(done_valid), 128'd0);
    check("mr_err", 128'(err_underflow), 128'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
